// File: rtl/morse_char_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_char_decoder_pkg
// Description : Shared constants and state encoding for the Morse character
//               decoder (ASCII codes, default code length, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package morse_char_decoder_pkg;

    localparam logic [7:0] c_ASCII_SPACE      = 8'h20;
    localparam logic [7:0] c_ASCII_UNKNOWN    = 8'h3F;
    localparam int         c_MAX_SYMBOLS_DFLT = 5;

    // S_IDLE: no group pending, S_COLLECT: group pending, S_SPACE: word-gap space owed
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_SPACE   = 2'd2
    } state_t;

endpackage : morse_char_decoder_pkg
`default_nettype wire

// File: rtl/morse_char_decoder_lut.sv
`default_nettype none
// ============================================================================
// Module      : morse_lut
// Description : Pure combinational Morse code lookup. The key is the symbol
//               count plus the symbol bits (first symbol MSB-side, dot=0,
//               dash=1, right-aligned). Covers A-Z and 0-9; anything else
//               returns UNKNOWN_CHAR.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_lut
    import morse_char_decoder_pkg::*;
#(
    parameter int         MAX_SYMBOLS  = c_MAX_SYMBOLS_DFLT,
    parameter int         LEN_W        = $clog2(MAX_SYMBOLS + 1),
    parameter logic [7:0] UNKNOWN_CHAR = c_ASCII_UNKNOWN
) (
    input  logic [LEN_W-1:0]       sym_len,
    input  logic [MAX_SYMBOLS-1:0] sym_bits,
    output logic [7:0]             ascii
);

    // Every legal code fits in five symbols, so the table only ever needs a
    // 3-bit length and 5-bit pattern regardless of MAX_SYMBOLS.
    logic       w_len_ok;
    logic [7:0] w_key;

    assign w_len_ok = (32'(sym_len) <= 5);
    assign w_key    = {3'(sym_len), 5'(sym_bits)};

    // Table lookup: {len, bits} -> ASCII
    always_comb begin
        ascii = UNKNOWN_CHAR;
        if (w_len_ok) begin
            case (w_key)
                8'b001_00000: ascii = 8'h45; // E .
                8'b001_00001: ascii = 8'h54; // T -
                8'b010_00001: ascii = 8'h41; // A .-
                8'b010_00000: ascii = 8'h49; // I ..
                8'b010_00011: ascii = 8'h4D; // M --
                8'b010_00010: ascii = 8'h4E; // N -.
                8'b011_00100: ascii = 8'h44; // D -..
                8'b011_00110: ascii = 8'h47; // G --.
                8'b011_00101: ascii = 8'h4B; // K -.-
                8'b011_00111: ascii = 8'h4F; // O ---
                8'b011_00010: ascii = 8'h52; // R .-.
                8'b011_00000: ascii = 8'h53; // S ...
                8'b011_00001: ascii = 8'h55; // U ..-
                8'b011_00011: ascii = 8'h57; // W .--
                8'b100_01000: ascii = 8'h42; // B -...
                8'b100_01010: ascii = 8'h43; // C -.-.
                8'b100_00010: ascii = 8'h46; // F ..-.
                8'b100_00000: ascii = 8'h48; // H ....
                8'b100_00111: ascii = 8'h4A; // J .---
                8'b100_00100: ascii = 8'h4C; // L .-..
                8'b100_00110: ascii = 8'h50; // P .--.
                8'b100_01101: ascii = 8'h51; // Q --.-
                8'b100_00001: ascii = 8'h56; // V ...-
                8'b100_01001: ascii = 8'h58; // X -..-
                8'b100_01011: ascii = 8'h59; // Y -.--
                8'b100_01100: ascii = 8'h5A; // Z --..
                8'b101_11111: ascii = 8'h30; // 0 -----
                8'b101_01111: ascii = 8'h31; // 1 .----
                8'b101_00111: ascii = 8'h32; // 2 ..---
                8'b101_00011: ascii = 8'h33; // 3 ...--
                8'b101_00001: ascii = 8'h34; // 4 ....-
                8'b101_00000: ascii = 8'h35; // 5 .....
                8'b101_10000: ascii = 8'h36; // 6 -....
                8'b101_11000: ascii = 8'h37; // 7 --...
                8'b101_11100: ascii = 8'h38; // 8 ---..
                8'b101_11110: ascii = 8'h39; // 9 ----.
                default:      ascii = UNKNOWN_CHAR;
            endcase
        end
    end

endmodule : morse_lut
`default_nettype wire

// File: rtl/morse_char_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_char_decoder
// Description : Accumulates dot/dash pulses into a symbol group, decodes the
//               group on a letter/word gap, inserts a space after word gaps
//               and queues characters in a small FIFO with a valid/ready
//               output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_char_decoder
    import morse_char_decoder_pkg::*;
#(
    parameter int         MAX_SYMBOLS  = c_MAX_SYMBOLS_DFLT,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] UNKNOWN_CHAR = c_ASCII_UNKNOWN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dot,
    input  logic       dash,
    input  logic       lg,
    input  logic       wg,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       overrun,
    output logic       busy
);

    localparam int c_LEN_W = $clog2(MAX_SYMBOLS + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    state_t                 r_state;
    logic [MAX_SYMBOLS-1:0] r_sym_bits;
    logic [c_LEN_W-1:0]     r_sym_len;
    logic                   r_overlong;

    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic       w_sym;
    logic       w_gap;
    logic [7:0] w_lut_char;
    logic [7:0] w_dec_char;
    logic       w_push;
    logic [7:0] w_push_data;
    logic       w_pop;
    logic       w_full;
    logic       w_wr;

    // Gaps win over symbols in the same cycle; dash wins over dot (bit = dash).
    assign w_sym = dot | dash;
    assign w_gap = lg | wg;

    morse_lut #(
        .MAX_SYMBOLS  (MAX_SYMBOLS),
        .LEN_W        (c_LEN_W),
        .UNKNOWN_CHAR (UNKNOWN_CHAR)
    ) u_lut (
        .sym_len  (r_sym_len),
        .sym_bits (r_sym_bits),
        .ascii    (w_lut_char)
    );

    assign w_dec_char = r_overlong ? UNKNOWN_CHAR : w_lut_char;

    // Select what, if anything, goes into the queue this cycle
    always_comb begin
        w_push      = 1'b0;
        w_push_data = w_dec_char;
        case (r_state)
            S_IDLE: begin
                if (wg) begin
                    w_push      = 1'b1;
                    w_push_data = c_ASCII_SPACE;
                end
            end
            S_COLLECT: begin
                if (w_gap) begin
                    w_push      = 1'b1;
                    w_push_data = w_dec_char;
                end
            end
            S_SPACE: begin
                w_push      = 1'b1;
                w_push_data = c_ASCII_SPACE;
            end
            default: ;
        endcase
    end

    // Group state machine and symbol register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sym_bits <= '0;
            r_sym_len  <= '0;
            r_overlong <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_SPACE: begin
                    // A space owed from S_SPACE is pushed by the mux regardless.
                    if (!w_gap && w_sym) begin
                        r_sym_bits <= {{(MAX_SYMBOLS-1){1'b0}}, dash};
                        r_sym_len  <= c_LEN_W'(1);
                        r_overlong <= 1'b0;
                        r_state    <= S_COLLECT;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_COLLECT: begin
                    if (w_gap) begin
                        r_sym_bits <= '0;
                        r_sym_len  <= '0;
                        r_overlong <= 1'b0;
                        r_state    <= wg ? S_SPACE : S_IDLE;
                    end else if (w_sym) begin
                        if (r_sym_len == c_LEN_W'(MAX_SYMBOLS)) begin
                            r_overlong <= 1'b1;
                        end else begin
                            r_sym_bits <= {r_sym_bits[MAX_SYMBOLS-2:0], dash};
                            r_sym_len  <= r_sym_len + c_LEN_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO control: a full queue still accepts a push when the head leaves in
    // the same cycle. FIFO_DEPTH is a power of two, so pointers wrap naturally.
    assign w_pop  = (r_count != '0) & char_ready;
    assign w_full = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_wr   = w_push & (~w_full | w_pop);

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_wr) - c_CNT_W'(w_pop);
        end
    end

    // Queue storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign char_valid = (r_count != '0);
    assign char_data  = char_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign overrun    = w_push & w_full & ~w_pop;
    assign busy       = (r_state != S_IDLE);

endmodule : morse_char_decoder
`default_nettype wire

// File: tb/tb_morse_char_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_char_decoder
// Description : Directed scoreboard bench for morse_char_decoder. Stimulus
//               pushes hand-computed characters into a queue; a monitor pops
//               and compares on every accepted output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_char_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       dot, dash, lg, wg;
    logic       char_ready;
    logic [7:0] char_data;
    logic       char_valid;
    logic       overrun;
    logic       busy;

    logic [7:0] sb [$];
    logic [7:0] mon_exp;
    int         n_vec = 0;
    int         n_err = 0;

    morse_char_decoder #(
        .MAX_SYMBOLS  (5),
        .FIFO_DEPTH   (4),
        .UNKNOWN_CHAR (8'h3F)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dot        (dot),
        .dash       (dash),
        .lg         (lg),
        .wg         (wg),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every beat accepted by the sink must match the scoreboard head
    always @(negedge clk) begin
        if (reset_n === 1'b1 && char_valid === 1'b1 && char_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_char: got %h expected none", char_data);
            end else begin
                mon_exp = sb.pop_front();
                check("char", char_data, mon_exp);
            end
        end
    end

    // Each call starts and ends just after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic p_dot, input logic p_dash, input logic p_lg,
                         input logic p_wg, input logic exp_ovr);
        dot  = p_dot;
        dash = p_dash;
        lg   = p_lg;
        wg   = p_wg;
        @(negedge clk);
        check("overrun", {7'd0, overrun}, {7'd0, exp_ovr});
        @(posedge clk);
        #1;
        dot  = 1'b0;
        dash = 1'b0;
        lg   = 1'b0;
        wg   = 1'b0;
    endtask

    // Send a '.'/'-' group followed by a letter gap
    task automatic send(input string code, input logic [7:0] exp_char,
                        input logic exp_ovr, input logic queued);
        for (int i = 0; i < code.len(); i++) begin
            pulse(code[i] == 8'h2E, code[i] == 8'h2D, 1'b0, 1'b0, 1'b0);
            idle(2);
        end
        if (queued) sb.push_back(exp_char);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, exp_ovr);
        idle(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) idle(1);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        idle(1);
        check("valid_after_drain", {7'd0, char_valid}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        dot        = 1'b0;
        dash       = 1'b0;
        lg         = 1'b0;
        wg         = 1'b0;
        char_ready = 1'b1;
        idle(3);
        check("rst_valid",   {7'd0, char_valid}, 8'h00);
        check("rst_data",    char_data,          8'h00);
        check("rst_busy",    {7'd0, busy},       8'h00);
        check("rst_overrun", {7'd0, overrun},    8'h00);
        reset_n = 1'b1;
        idle(1);

        // 'A' .- : visible the cycle after lg, busy drops
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(2);
        check("a_busy_before", {7'd0, busy}, 8'h01);
        sb.push_back(8'h41);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("a_valid_latency", {7'd0, char_valid}, 8'h01);
        check("a_data_latency",  char_data,          8'h41);
        check("a_busy_after",    {7'd0, busy},       8'h00);
        drain();

        // 'B' -... then word gap: B and space on consecutive beats
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(2);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(2);
        end
        sb.push_back(8'h42);
        sb.push_back(8'h20);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b_space_state",  {7'd0, busy}, 8'h01);
        check("b_data",         char_data,    8'h42);
        idle(1);
        check("b_space_left",   {7'd0, busy}, 8'h00);
        check("b_space_data",   char_data,    8'h20);
        drain();

        // Boundary codes: longest legal, overlong, unmapped, mixed
        send("-----",  8'h30, 1'b0, 1'b1);
        send("......", 8'h3F, 1'b0, 1'b1);
        send("..--",   8'h3F, 1'b0, 1'b1);
        send("-.-",    8'h4B, 1'b0, 1'b1);
        send("....-",  8'h34, 1'b0, 1'b1);
        sb.push_back(8'h20);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Stalled sink: fifth group is dropped with an overrun pulse
        char_ready = 1'b0;
        send(".", 8'h45, 1'b0, 1'b1);
        send("-", 8'h54, 1'b0, 1'b1);
        send(".", 8'h45, 1'b0, 1'b1);
        send("-", 8'h54, 1'b0, 1'b1);
        send(".", 8'h45, 1'b1, 1'b0);
        check("stall_head", char_data, 8'h45);
        char_ready = 1'b1;
        drain();

        // Full queue with a same-cycle pop: the push succeeds
        char_ready = 1'b0;
        send(".", 8'h45, 1'b0, 1'b1);
        send("-", 8'h54, 1'b0, 1'b1);
        send(".", 8'h45, 1'b0, 1'b1);
        send("-", 8'h54, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(2);
        sb.push_back(8'h54);
        char_ready = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // Mid-group reset discards the group
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(1);
        check("rst_mid_busy", {7'd0, busy}, 8'h01);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("rst_mid_busy_after",  {7'd0, busy},       8'h00);
        check("rst_mid_valid_after", {7'd0, char_valid}, 8'h00);

        // dot and dash together count as a dash
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(2);
        sb.push_back(8'h54);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_morse_char_decoder
`default_nettype wire
